// File: rtl/centipede_cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// centipede_cpu_ctrl_pkg
//
// Shared definitions for the Centipede CPU control block: default timing
// constants for the phase divider, reset hold and watchdog, the counter width
// used by the hold and watchdog counters, and the reset sequencer state type.
// -----------------------------------------------------------------------------
package centipede_cpu_ctrl_pkg;

  // Master clocks per phi0 period (even, >= 4).
  localparam int CLK_DIV_DEF     = 8;
  // phi0 periods the CPU is held in reset after any reset cause (1..255).
  localparam int RESET_HOLD_DEF  = 32;
  // vblank rising edges without a kick before the watchdog fires (1..255).
  localparam int WDOG_FRAMES_DEF = 16;

  // Both the hold counter and the watchdog frame counter cover 0..255.
  localparam int CTR_W = 8;

  // Reset sequencer: RUN lets the CPU execute, HOLD keeps it in reset.
  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } seq_state_e;

endpackage

// File: rtl/centipede_cpu_ctrl_sync_rise.sv
// -----------------------------------------------------------------------------
// sync_rise
//
// Brings an asynchronous level into the clk domain through a 2-FF synchronizer
// and emits a one-clk pulse on each synchronized rising edge. The pulse is
// combinational from the synchronizer output and its delayed copy, so a
// consumer that registers on it reacts 3 clks after the input rises.
//
// Ports:
//   clk      in  master clock
//   reset_n  in  asynchronous active-low reset (all stages cleared to 0)
//   din      in  asynchronous level
//   rise     out one-clk pulse on a synchronized 0->1 transition
// -----------------------------------------------------------------------------
module sync_rise (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  // sr[0], sr[1]: synchronizer stages; sr[2]: previous synchronized value.
  logic [2:0] sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[1:0], din};
    end
  end

  assign rise = sr[1] & ~sr[2];

endmodule

// File: rtl/centipede_cpu_ctrl.sv
// -----------------------------------------------------------------------------
// centipede_cpu_ctrl
//
// Produces the 6502 phase clock, CPU reset and IRQ from the master clock and
// the video/decoder strobes, and implements the board watchdog that resets
// the CPU when the program stops writing the watchdog register.
//
// Build option: define CENTIPEDE_WATCHDOG_EN to include the watchdog. Without
// it, wdog_clr is ignored, wdog_rst is tied low and the CPU is held in reset
// only after reset_n.
//
// Parameters:
//   CLK_DIV      clk cycles per phi0 period (even, >= 4)
//   RESET_HOLD   phi0 periods cpu_reset_n stays low after a reset cause
//   WDOG_FRAMES  unkicked vblank edges before the watchdog fires
//
// Ports:
//   clk          in  master clock, all logic on its rising edge
//   reset_n      in  asynchronous active-low reset
//   v32          in  vertical count bit 32 (asynchronous), IRQ source
//   vblank       in  vertical blank level (asynchronous), watchdog tick
//   irq_ack      in  one-clk pulse, IRQ acknowledge write
//   wdog_clr     in  one-clk pulse, watchdog kick write
//   phi0         out CPU phase clock, high for the first half of the period
//   cpu_ce       out one-clk pulse in the last clk of each phi0 period
//   cpu_reset_n  out active-low CPU reset
//   irq          out active-high interrupt request (level until acked)
//   wdog_rst     out high while a watchdog-caused reset is being held
// -----------------------------------------------------------------------------
module centipede_cpu_ctrl
  import centipede_cpu_ctrl_pkg::*;
#(
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int RESET_HOLD  = RESET_HOLD_DEF,
  parameter int WDOG_FRAMES = WDOG_FRAMES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic v32,
  input  logic vblank,
  input  logic irq_ack,
  input  logic wdog_clr,
  output logic phi0,
  output logic cpu_ce,
  output logic cpu_reset_n,
  output logic irq,
  output logic wdog_rst
);

  localparam int DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] CNT_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] CNT_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [CTR_W-1:0] HOLD_LAST = CTR_W'(RESET_HOLD - 1);
  localparam logic [CTR_W-1:0] WD_LAST   = CTR_W'(WDOG_FRAMES - 1);

  // ---------------------------------------------------------------------------
  // Phase divider
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;

  assign cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

  // phi0 and cpu_ce are decoded from the next count so that, as registers,
  // they line up with cnt itself: phi0 == (cnt < CLK_DIV/2) and
  // cpu_ce == (cnt == CLK_DIV-1) in every clk after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      phi0   <= 1'b0;
      cpu_ce <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all clocked state, so every
      // register samples values from before the edge regardless of order.
      cnt    <= cnt_nxt;
      phi0   <= (cnt_nxt < CNT_HALF);
      cpu_ce <= (cnt_nxt == CNT_LAST);
    end
  end

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic v32_rise;
  logic vblank_rise;

  sync_rise u_v32_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (v32),
    .rise    (v32_rise)
  );

  sync_rise u_vblank_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (vblank),
    .rise    (vblank_rise)
  );

  // ---------------------------------------------------------------------------
  // Reset sequencer
  // ---------------------------------------------------------------------------
  seq_state_e       state;
  seq_state_e       state_nxt;
  logic [CTR_W-1:0] hold_cnt;
  logic [CTR_W-1:0] hold_cnt_nxt;
  logic             wd_fire;
  logic             hold_exit;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      HOLD: begin
        // The final count lands on the last clk of a phi0 period, so the CPU
        // leaves reset on the following phi0 rising edge.
        if (cpu_ce) begin
          if (hold_cnt == HOLD_LAST) begin
            state_nxt    = RUN;
            hold_cnt_nxt = '0;
          end else begin
            hold_cnt_nxt = hold_cnt + 1'b1;
          end
        end
      end
      RUN: begin
        // A watchdog fire is not phase aligned; the hold simply counts the
        // next RESET_HOLD cpu_ce pulses from wherever it starts.
        if (wd_fire) begin
          state_nxt    = HOLD;
          hold_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt = HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= HOLD;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  assign hold_exit   = (state == HOLD) && (state_nxt == RUN);
  assign cpu_reset_n = (state == RUN);

  // ---------------------------------------------------------------------------
  // Interrupt request
  // ---------------------------------------------------------------------------
  // A watchdog fire clears the request; otherwise a new v32 edge beats an
  // acknowledge arriving in the same clk so no interrupt is lost.
  logic irq_nxt;

  always_comb begin
    irq_nxt = irq;
    if (wd_fire) begin
      irq_nxt = 1'b0;
    end else if (v32_rise) begin
      irq_nxt = 1'b1;
    end else if (irq_ack) begin
      irq_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
`ifdef CENTIPEDE_WATCHDOG_EN
  logic [CTR_W-1:0] wd_cnt;
  logic [CTR_W-1:0] wd_cnt_nxt;

  // Frames are not counted while the CPU is held in reset, and a kick in the
  // same clk as a frame edge wins so the program is never penalised for it.
  always_comb begin
    wd_cnt_nxt = wd_cnt;
    wd_fire    = 1'b0;
    if ((state == HOLD) || wdog_clr) begin
      wd_cnt_nxt = '0;
    end else if (vblank_rise) begin
      if (wd_cnt == WD_LAST) begin
        wd_fire    = 1'b1;
        wd_cnt_nxt = '0;
      end else begin
        wd_cnt_nxt = wd_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt   <= '0;
      wdog_rst <= 1'b0;
    end else begin
      wd_cnt <= wd_cnt_nxt;
      if (wd_fire) begin
        wdog_rst <= 1'b1;
      end else if (hold_exit) begin
        wdog_rst <= 1'b0;
      end
    end
  end
`else
  // Without the watchdog the frame edge and kick strobe have no consumer.
  logic unused_wd;

  assign wd_fire   = 1'b0;
  assign wdog_rst  = 1'b0;
  assign unused_wd = ^{wdog_clr, vblank_rise, hold_exit, WD_LAST};
`endif

endmodule

// File: tb/tb_centipede_cpu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_centipede_cpu_ctrl
//
// Directed bench for centipede_cpu_ctrl with CLK_DIV=8, RESET_HOLD=4,
// WDOG_FRAMES=3. Stimulus steps push the expected output values, tagged with
// the sample cycle at which they are due, into a scoreboard queue; every
// falling clock edge pops and compares whatever has come due. Watchdog
// scenarios follow the CENTIPEDE_WATCHDOG_EN build option.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_centipede_cpu_ctrl;

  localparam int CLK_DIV     = 8;
  localparam int RESET_HOLD  = 4;
  localparam int WDOG_FRAMES = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic v32;
  logic vblank;
  logic irq_ack;
  logic wdog_clr;
  logic phi0;
  logic cpu_ce;
  logic cpu_reset_n;
  logic irq;
  logic wdog_rst;

  centipede_cpu_ctrl #(
    .CLK_DIV     (CLK_DIV),
    .RESET_HOLD  (RESET_HOLD),
    .WDOG_FRAMES (WDOG_FRAMES)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .v32         (v32),
    .vblank      (vblank),
    .irq_ack     (irq_ack),
    .wdog_clr    (wdog_clr),
    .phi0        (phi0),
    .cpu_ce      (cpu_ce),
    .cpu_reset_n (cpu_reset_n),
    .irq         (irq),
    .wdog_rst    (wdog_rst)
  );

  always #5 clk = ~clk;

  typedef enum int {S_PHI0, S_CE, S_RSTN, S_IRQ, S_WDR} sig_e;

  typedef struct {
    int    due;
    sig_e  sig;
    logic  val;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;   // falling edges seen
  int   base    = 0;   // cyc at the last reset_n release
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic obs, input logic expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  function automatic logic sample(input sig_e s);
    case (s)
      S_PHI0:  return phi0;
      S_CE:    return cpu_ce;
      S_RSTN:  return cpu_reset_n;
      S_IRQ:   return irq;
      default: return wdog_rst;
    endcase
  endfunction

  // Expect signal s to equal v at the sample taken 'delay' falling edges from now.
  task automatic expect_at(input int delay, input sig_e s, input logic v, input string tag);
    exp_t e;
    e.due = cyc + delay;
    e.sig = s;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Advance to the next falling edge and compare everything that has come due.
  task automatic tick();
    int i;
    @(negedge clk);
    cyc++;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        check(sb[i].tag, sample(sb[i].sig), sb[i].val);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic drain();
    for (int g = 0; g < 100 && sb.size() > 0; g++) tick();
    check("sb_drained", logic'(sb.size() == 0), 1'b1);
    sb.delete();
  endtask

  task automatic wait_phase(input int p);
    for (int g = 0; g < CLK_DIV && ((cyc - base) % CLK_DIV) != p; g++) tick();
  endtask

  // Last sample cycle at which cpu_reset_n is still low for a hold that
  // starts at sample cycle e, plus one: the RESET_HOLD-th counter wrap after e.
  function automatic int hold_end(input int e);
    int n;
    n = e + 1;
    while (((n - base) % CLK_DIV) != 0) n++;
    return n + CLK_DIV * (RESET_HOLD - 1);
  endfunction

  // One vblank pulse of 4 high / 4 low clks; optionally a kick in the clk
  // where the synchronized edge is seen.
  task automatic vb_pulse(input bit with_clr);
    vblank = 1'b1;
    tick();
    tick();
    if (with_clr) wdog_clr = 1'b1;
    tick();
    wdog_clr = 1'b0;
    tick();
    vblank = 1'b0;
    repeat (4) tick();
  endtask

  task automatic check_all_reset(input string pfx);
    check({pfx, "_phi0"}, phi0, 1'b0);
    check({pfx, "_ce"},   cpu_ce, 1'b0);
    check({pfx, "_rstn"}, cpu_reset_n, 1'b0);
    check({pfx, "_irq"},  irq, 1'b0);
    check({pfx, "_wdr"},  wdog_rst, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    int h;
    reset_n  = 1'b0;
    v32      = 1'b0;
    vblank   = 1'b0;
    irq_ack  = 1'b0;
    wdog_clr = 1'b0;

    // Reset state with the clock running.
    repeat (3) tick();
    check_all_reset("por");

    // Release: divider pattern and the 32-clk hold.
    reset_n = 1'b1;
    base    = cyc;
    for (int k = 1; k <= 40; k++) begin
      expect_at(k, S_PHI0, logic'((k % CLK_DIV) < CLK_DIV / 2), $sformatf("phi0_k%0d", k));
      expect_at(k, S_CE, logic'((k % CLK_DIV) == CLK_DIV - 1), $sformatf("ce_k%0d", k));
    end
    expect_at(1,  S_RSTN, 1'b0, "rstn_k1");
    expect_at(16, S_RSTN, 1'b0, "rstn_k16");
    expect_at(31, S_RSTN, 1'b0, "rstn_k31");
    expect_at(32, S_RSTN, 1'b1, "rstn_k32");
    expect_at(32, S_PHI0, 1'b1, "rstn_phi0_k32");
    expect_at(40, S_RSTN, 1'b1, "rstn_k40");
    expect_at(32, S_WDR,  1'b0, "wdr_after_por");
    drain();

    // IRQ latency and acknowledge.
    v32 = 1'b1;
    expect_at(2, S_IRQ, 1'b0, "irq_lat_2");
    expect_at(3, S_IRQ, 1'b1, "irq_lat_3");
    repeat (13) tick();
    check("irq_level", irq, 1'b1);
    irq_ack = 1'b1;
    expect_at(1, S_IRQ, 1'b0, "irq_ack_clr");
    tick();
    irq_ack = 1'b0;
    v32     = 1'b0;
    repeat (4) tick();

    // Edge and acknowledge in the same clk, from irq low and from irq high.
    v32 = 1'b1;
    tick();
    tick();
    irq_ack = 1'b1;
    expect_at(1, S_IRQ, 1'b1, "set_wins_from_0");
    tick();
    irq_ack = 1'b0;
    repeat (3) tick();
    v32 = 1'b0;
    repeat (4) tick();
    v32 = 1'b1;
    tick();
    tick();
    irq_ack = 1'b1;
    expect_at(1, S_IRQ, 1'b1, "set_wins_from_1");
    tick();
    irq_ack = 1'b1;
    expect_at(1, S_IRQ, 1'b0, "ack_alone");
    tick();
    irq_ack = 1'b0;
    v32     = 1'b0;
    repeat (4) tick();
    drain();

`ifdef CENTIPEDE_WATCHDOG_EN
    // Arm irq so the fire visibly clears it.
    v32 = 1'b1;
    expect_at(3, S_IRQ, 1'b1, "wd_irq_armed");
    repeat (4) tick();

    // Three unkicked frames, third fire aligned to a counter wrap.
    wait_phase(5);
    vb_pulse(1'b0);
    vb_pulse(1'b0);
    expect_at(2,  S_RSTN, 1'b1, "wd_pre_rstn");
    expect_at(2,  S_WDR,  1'b0, "wd_pre_wdr");
    expect_at(3,  S_RSTN, 1'b0, "wd_fire_rstn");
    expect_at(3,  S_WDR,  1'b1, "wd_fire_wdr");
    expect_at(3,  S_IRQ,  1'b0, "wd_fire_irq");
    expect_at(16, S_RSTN, 1'b0, "wd_mid_hold");
    expect_at(34, S_RSTN, 1'b0, "wd_hold_last");
    expect_at(34, S_WDR,  1'b1, "wd_wdr_last");
    expect_at(35, S_RSTN, 1'b1, "wd_release_rstn");
    expect_at(35, S_WDR,  1'b0, "wd_release_wdr");
    vb_pulse(1'b0);
    drain();

    // Two frames, a kick coinciding with the second edge, two more frames:
    // no reset. A third frame after the kick then fires.
    vb_pulse(1'b0);
    vb_pulse(1'b1);
    for (int p = 0; p < 2; p++) begin
      expect_at(3, S_RSTN, 1'b1, $sformatf("kick_no_fire_%0d", p));
      expect_at(4, S_WDR,  1'b0, $sformatf("kick_no_wdr_%0d", p));
      vb_pulse(1'b0);
    end
    e = cyc + 3;
    h = hold_end(e);
    expect_at(3, S_RSTN, 1'b0, "kick_third_fire");
    expect_at(3, S_WDR,  1'b1, "kick_third_wdr");
    expect_at(h - cyc - 1, S_RSTN, 1'b0, "kick_hold_last");
    expect_at(h - cyc, S_RSTN, 1'b1, "kick_release");
    expect_at(h - cyc, S_WDR,  1'b0, "kick_release_wdr");
    vb_pulse(1'b0);
    drain();
`else
    // Watchdog absent: ten frames with occasional kicks never reset the CPU.
    for (int p = 0; p < 10; p++) begin
      expect_at(3, S_RSTN, 1'b1, $sformatf("nowd_rstn_%0d", p));
      expect_at(3, S_WDR,  1'b0, $sformatf("nowd_wdr_%0d", p));
      vb_pulse(p == 4);
    end
    drain();
`endif

    // Asynchronous reset in RUN with irq and phi0 high.
    v32 = 1'b0;
    repeat (4) tick();
    v32 = 1'b1;
    expect_at(3, S_IRQ, 1'b1, "irq_pre_run_rst");
    repeat (4) tick();
    wait_phase(2);
    check("pre_run_rst_phi0", phi0, 1'b1);
    check("pre_run_rst_rstn", cpu_reset_n, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_all_reset("async_run");
    v32 = 1'b0;
    tick();
    tick();

    // Asynchronous reset mid-HOLD restarts the full hold.
    reset_n = 1'b1;
    base    = cyc;
    repeat (10) tick();
    check("pre_hold_rst_phi0", phi0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_all_reset("async_hold");
    tick();
    tick();
    reset_n = 1'b1;
    base    = cyc;
    for (int k = 1; k <= 8; k++) begin
      expect_at(k, S_PHI0, logic'((k % CLK_DIV) < CLK_DIV / 2), $sformatf("re_phi0_k%0d", k));
    end
    expect_at(7,  S_CE,   1'b1, "re_ce_k7");
    expect_at(31, S_RSTN, 1'b0, "re_rstn_k31");
    expect_at(32, S_RSTN, 1'b1, "re_rstn_k32");
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
